// File: rtl/vslc_servo_pkg.sv
// Shared constants and helpers for the VSLC servo bank: default 1 us tick,
// standard 20 ms hobby-servo frame, pulse clamp and channel-index width.
package vslc_servo_pkg;

  localparam int unsigned US_TICK_DIV     = 10;
  localparam int unsigned SERVO_FRAME_US  = 20000;
  localparam int unsigned SERVO_PW_MIN_US = 500;
  localparam int unsigned SERVO_PW_MAX_US = 2500;

  // Index width for n channels, never below one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Zero keeps a channel off; any other request is forced into [lo, hi].
  function automatic int unsigned clamp_pw(input int unsigned v,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (v == 0) return 0;
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vslc_servo_bank_if.sv
// Write and readback bus between the scan/SPI side and the servo bank.
interface vslc_servo_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 15
);
  import vslc_servo_pkg::*;

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_data;

  modport master (output wr_en, wr_ch, wr_data, rd_ch, input rd_data);
  modport slave  (input wr_en, wr_ch, wr_data, rd_ch, output rd_data);

endinterface

// File: rtl/vslc_tick_prescaler.sv
// Free-running divider: tick is high for one clk out of every DIV.
module vslc_tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/vslc_servo_bank.sv
// NUM_CH hobby-servo PWM outputs sharing one tick and frame counter; widths
// are shadowed and committed atomically at the frame boundary unless frozen.
module vslc_servo_bank
  import vslc_servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 15,
  parameter int unsigned CLK_DIV     = US_TICK_DIV,
  parameter int unsigned FRAME_TICKS = SERVO_FRAME_US,
  parameter int unsigned PW_MIN      = SERVO_PW_MIN_US,
  parameter int unsigned PW_MAX      = SERVO_PW_MAX_US
) (
  input  logic                    clk,
  input  logic                    rst,
  vslc_servo_bank_if.slave        bus,
  input  logic                    freeze,
  output logic [NUM_CH-1:0]       servo_out,
  output logic                    frame_strobe,
  output logic                    pending
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);

  logic             tick;
  logic             commit;
  logic             wr_valid;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] pw_clamped;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] active [NUM_CH];

  vslc_tick_prescaler #(.DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign commit     = tick && (frame_cnt == FRAME_LAST);
  assign wr_valid   = bus.wr_en && (32'(bus.wr_ch) < NUM_CH);
  assign pw_clamped = CNT_W'(clamp_pw(32'(bus.wr_data), PW_MIN, PW_MAX));

  always_ff @(posedge clk) begin
    if (rst)         frame_cnt <= '0;
    else if (commit) frame_cnt <= '0;
    else if (tick)   frame_cnt <= frame_cnt + CNT_W'(1);
  end

  // A write landing in the commit cycle wins, so pending survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_strobe <= 1'b0;
      pending      <= 1'b0;
    end else begin
      frame_strobe <= commit;
      if (wr_valid)               pending <= 1'b1;
      else if (commit && !freeze) pending <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] act_q;
    logic             out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        act_q  <= '0;
        out_q  <= 1'b0;
      end else begin
        if (commit && !freeze) act_q <= shadow;
        if (wr_valid && (bus.wr_ch == CH_W'(i))) shadow <= pw_clamped;
        out_q <= (act_q != '0) && (frame_cnt < act_q);
      end
    end

    assign active[i]    = act_q;
    assign servo_out[i] = out_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_W'(i)) rd_mux = active[i];
    end
  end

  assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_vslc_servo_bank.sv
// Self-checking bench for vslc_servo_bank: directed frame scenarios plus a
// randomized phase, all compared cycle by cycle against a frame-level model.
`timescale 1ns/1ps
module tb_vslc_servo_bank;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned FRAME_TICKS = 20;
  localparam int unsigned PW_MIN      = 2;
  localparam int unsigned PW_MAX      = 15;
  localparam int unsigned FRAME_CLK   = CLK_DIV * FRAME_TICKS;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze;
  logic [NUM_CH-1:0] servo_out;
  logic              frame_strobe;
  logic              pending;

  vslc_servo_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  vslc_servo_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_DIV(CLK_DIV),
    .FRAME_TICKS(FRAME_TICKS), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .freeze       (freeze),
    .servo_out    (servo_out),
    .frame_strobe (frame_strobe),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: time is the cycle count since reset release.
  int unsigned       m_n;
  int unsigned       m_shadow [NUM_CH];
  int unsigned       m_active [NUM_CH];
  bit                m_pending;
  bit                m_strobe;
  logic [NUM_CH-1:0] m_servo;

  function automatic int unsigned ref_clamp(input int unsigned v);
    if (v == 0) return 0;
    if (v < PW_MIN) return PW_MIN;
    if (v > PW_MAX) return PW_MAX;
    return v;
  endfunction

  task automatic model_update();
    int unsigned fc;
    bit          cmt;
    if (rst) begin
      m_n = 0;
      m_pending = 0;
      m_strobe = 0;
      m_servo = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      fc  = (m_n / CLK_DIV) % FRAME_TICKS;
      cmt = ((m_n % CLK_DIV) == CLK_DIV - 1) && (fc == FRAME_TICKS - 1);
      for (int i = 0; i < NUM_CH; i++)
        m_servo[i] = (m_active[i] != 0) && (fc < m_active[i]);
      m_strobe = cmt;
      if (cmt && !freeze) begin
        for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end
      if (bus.wr_en && (int'(bus.wr_ch) < NUM_CH)) begin
        m_shadow[bus.wr_ch] = ref_clamp(int'(bus.wr_data));
        m_pending = 1;
      end
      m_n++;
    end
  endtask

  task automatic check_outputs();
    check_eq("servo_out", 32'(servo_out), 32'(m_servo));
    check_eq("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
    check_eq("pending", 32'(pending), 32'(m_pending));
    check_eq("rd_data", 32'(bus.rd_data), m_active[bus.rd_ch]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic write_ch(input int ch, input int unsigned val);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_data = 5'(val);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_ch(input int ch, output int unsigned v);
    bus.rd_ch = 2'(ch);
    #1;
    v = int'(bus.rd_data);
  endtask

  task automatic wait_strobe();
    int k = 0;
    step();
    while (!frame_strobe && k < 3 * FRAME_CLK) begin
      step();
      k++;
    end
    check_eq("strobe_wait", 32'(frame_strobe), 1);
  endtask

  task automatic measure_high(input int ch, input int unsigned len, output int unsigned hi);
    hi = 0;
    for (int k = 0; k < int'(len); k++) begin
      step();
      if (servo_out[ch]) hi++;
    end
  endtask

  initial begin
    int unsigned v;
    int unsigned hi;
    int unsigned sc;

    rst = 1'b1;
    freeze = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_data = '0;
    bus.rd_ch = '0;

    // Idle after reset: outputs low, strobe once per frame.
    do_reset();
    sc = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (frame_strobe) sc++;
    end
    check_eq("idle_strobe_count", sc, 200 / FRAME_CLK);

    // Basic write and commit on ch0.
    do_reset();
    step(); step(); step();
    write_ch(0, 5);
    check_eq("b_pending_after_write", 32'(pending), 1);
    wait_strobe();
    check_eq("b_pending_after_commit", 32'(pending), 0);
    read_ch(0, v);
    check_eq("b_rd_ch0", v, 5);
    measure_high(0, FRAME_CLK, hi);
    check_eq("b_ch0_high_clk", hi, 10);

    // Clamp rules.
    write_ch(1, 1);
    write_ch(2, 30);
    write_ch(3, 0);
    wait_strobe();
    read_ch(1, v); check_eq("c_rd_ch1", v, 2);
    read_ch(2, v); check_eq("c_rd_ch2", v, 15);
    read_ch(3, v); check_eq("c_rd_ch3", v, 0);
    bus.rd_ch = '0;
    measure_high(3, FRAME_CLK, hi);
    check_eq("c_ch3_high_clk", hi, 0);

    // Freeze holds the committed width and the pending flag.
    freeze = 1'b1;
    write_ch(0, 8);
    wait_strobe();
    check_eq("d_pending_frozen", 32'(pending), 1);
    read_ch(0, v); check_eq("d_rd_ch0_frozen", v, 5);
    measure_high(0, FRAME_CLK, hi);
    check_eq("d_ch0_high_frozen", hi, 10);
    freeze = 1'b0;
    wait_strobe();
    check_eq("d_pending_released", 32'(pending), 0);
    read_ch(0, v); check_eq("d_rd_ch0_released", v, 8);
    measure_high(0, FRAME_CLK, hi);
    check_eq("d_ch0_high_released", hi, 16);

    // Write landing exactly in the commit cycle.
    write_ch(0, 5);
    wait_strobe();
    while ((m_n % FRAME_CLK) != FRAME_CLK - 1) step();
    write_ch(0, 9);
    check_eq("e_strobe_at_commit", 32'(frame_strobe), 1);
    check_eq("e_pending_at_commit", 32'(pending), 1);
    read_ch(0, v); check_eq("e_rd_ch0_old", v, 5);
    measure_high(0, FRAME_CLK, hi);
    check_eq("e_ch0_high_old", hi, 10);
    check_eq("e_pending_next", 32'(pending), 0);
    read_ch(0, v); check_eq("e_rd_ch0_new", v, 9);
    measure_high(0, FRAME_CLK, hi);
    check_eq("e_ch0_high_new", hi, 18);

    // Reset in the middle of a pulse.
    step(); step(); step();
    check_eq("f_ch0_high_before_rst", 32'(servo_out[0]), 1);
    rst = 1'b1;
    step();
    check_eq("f_ch0_low_after_rst", 32'(servo_out[0]), 0);
    read_ch(0, v); check_eq("f_rd_ch0_after_rst", v, 0);
    step();
    rst = 1'b0;
    measure_high(0, 2 * FRAME_CLK, hi);
    check_eq("f_ch0_high_after_rst", hi, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 599) == 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_ch   = 2'($urandom_range(0, NUM_CH - 1));
      bus.wr_data = 5'($urandom_range(0, 31));
      bus.rd_ch   = 2'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      step();
    end
    rst = 1'b0;
    bus.wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vslc_servo_bank.md
Name: vslc_servo_bank

Overview:
- Multi-channel servo PWM generator for the VSLC core.
- Parametrised successor to the single-rate servo divider path. Provides NUM_CH independent hobby-servo outputs that share one prescaler and one frame counter.
- Pulse widths are written by the scan/SPI side into shadow registers. They are committed atomically at the frame boundary, clamped to a safe range, and can be frozen.

Parameters:
- NUM_CH, 4, number of servo channels (1..8).
- CNT_W, 15, width of frame counter and pulse-width registers.
- CLK_DIV, 10, clk cycles per tick (>=1); 10 MHz / 10 = 1 us tick.
- FRAME_TICKS, 20000, ticks per frame (<= 2^CNT_W).
- PW_MIN, 500, minimum non-zero pulse width in ticks.
- PW_MAX, 2500, maximum pulse width in ticks (PW_MIN <= PW_MAX < FRAME_TICKS).

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe, one cycle.
- wr_ch  in  $clog2(NUM_CH) (min 1)  channel to write.
- wr_data  in  CNT_W  requested pulse width in ticks; 0 = channel off.
- freeze  in  1  when high, frame commits are suppressed.
- rd_ch  in  $clog2(NUM_CH) (min 1)  readback channel select.
- rd_data  out  CNT_W  active (committed) width of rd_ch; combinational.
- servo_out  out  NUM_CH  PWM outputs, registered.
- frame_strobe  out  1  one-cycle pulse on each commit/frame start.
- pending  out  1  a shadow write is awaiting commit.

Behaviour:
- Reset values:
  - prescaler = 0, frame_cnt = 0.
  - All shadow and active registers = 0.
  - servo_out = 0, frame_strobe = 0, pending = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1; tick = 1 in the cycle where it equals CLK_DIV-1, then wraps to 0.
  - CLK_DIV = 1 gives tick every cycle.
- Frame counter:
  - Increments on tick.
  - At FRAME_TICKS-1 with tick, wraps to 0. That cycle is the commit cycle (commit = tick && frame_cnt == FRAME_TICKS-1).
- Write path:
  - On wr_en, shadow[wr_ch] <= clamp(wr_data), and pending <= 1.
  - clamp: 0 -> 0; 0 < v < PW_MIN -> PW_MIN; v > PW_MAX -> PW_MAX; otherwise v.
  - wr_ch >= NUM_CH: write ignored, pending unchanged.
- Commit:
  - On commit && !freeze: active[i] <= shadow[i] for all i, frame_strobe = 1 next cycle, and pending <= 0.
  - On commit && freeze: active is unchanged, pending is held, and frame_strobe still pulses (frame boundary marker).
- Simultaneous wr_en and commit:
  - active takes the pre-write shadow.
  - The new value lands in shadow; pending ends at 1 and the value applies next frame.
- Output:
  - servo_out[i] <= (active[i] != 0) && (frame_cnt < active[i]).
  - Registered, so there is one clk of latency relative to frame_cnt.
  - The high pulse spans active[i] ticks starting at frame start.
  - active = 0 -> output constantly low.
- Readback: rd_data = active[rd_ch]; rd_ch >= NUM_CH -> 0.
- Reset mid-frame:
  - All outputs go low in the next cycle.
  - Counters restart, and all channels are off until written and committed.
- Width rules:
  - Comparisons are unsigned CNT_W.
  - frame_cnt never exceeds FRAME_TICKS-1.

Decomposition:
- Package vslc_servo_pkg: clamp function; default tick/frame constants (US_TICK_DIV, SERVO_FRAME_US, SERVO_PW_MIN_US, SERVO_PW_MAX_US); channel-index width helper.
- Sub-module vslc_tick_prescaler (parameter DIV; ports clk, rst, tick). It is reused by the timer and SPI dividers.
- Channel compare logic stays in a generate loop in the parent.

Test Plan (bench params CLK_DIV=2, FRAME_TICKS=20, PW_MIN=2, PW_MAX=15, NUM_CH=4, CNT_W=5):
- Reset, no writes -> servo_out = 0 for 200 cycles; frame_strobe pulses every 40 cycles; pending = 0.
- Write ch0 = 5 at cycle 3 -> pending = 1 until first commit. Next frame: ch0 high exactly 10 clk (5 ticks) starting 1 clk after frame_cnt = 0. rd_data(rd_ch = 0) = 5 after commit.
- Clamp: write ch1 = 1 -> rd_data = 2 after commit. Write ch2 = 30 -> rd_data = 15. Write ch3 = 0 -> ch3 stays low.
- Freeze: commit ch0 = 5. Raise freeze, write ch0 = 8 -> next frame still 10 clk high, pending = 1. Drop freeze -> following frame 16 clk high, pending = 0.
- Simultaneous: wr_en ch0 = 9 in the exact commit cycle (shadow was 5) -> next frame width 5 ticks, pending = 1; following frame width 9 ticks.
- Reset asserted mid-pulse on ch0 -> servo_out = 0 the next cycle. rd_data = 0. Channel remains low through the following frame with no writes.
